// File: rtl/awg_pkg.sv
// Shared constants and small datapath helpers for the AWG waveform core.
// Sample words are 14-bit offset binary centred on MIDSCALE.
package awg_pkg;

    localparam int SAMPLE_W = 14;
    localparam int ACC_W    = 16;
    localparam int FREQ_W   = 12;
    localparam int AMP_W    = 4;
    localparam int PHASE_W  = 9;
    localparam int ROM_AW   = 8;
    localparam int ROM_DW   = 13;

    localparam logic [SAMPLE_W-1:0] MIDSCALE      = 14'd8192;
    localparam logic [ACC_W-1:0]    LFSR_SEED_DEF = 16'hACE1;

    // Fibonacci step for x^16+x^14+x^13+x^11+1
    function automatic logic [ACC_W-1:0] lfsr_next(input logic [ACC_W-1:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic logic [ROM_AW-1:0] quarter_index(input logic        mirror,
                                                        input logic [ROM_AW-1:0] i);
        logic [ROM_AW-1:0] idx;
        if (mirror) begin
            idx = ~i;
        end else begin
            idx = i;
        end
        return idx;
    endfunction

    // amp 0 mutes to midscale; amp n shrinks the swing about midscale by 2^(n-1)
    function automatic logic [SAMPLE_W-1:0] amp_scale(input logic [SAMPLE_W-1:0] s,
                                                      input logic [AMP_W-1:0]    amp);
        logic signed [SAMPLE_W:0] dev;
        logic [SAMPLE_W-1:0]      res;
        dev = $signed({1'b0, s}) - $signed({1'b0, MIDSCALE});
        if (amp == 4'd0) begin
            res = MIDSCALE;
        end else begin
            res = SAMPLE_W'(dev >>> (amp - 4'd1)) + MIDSCALE;
        end
        return res;
    endfunction

endpackage

// File: rtl/saw_sin_noise_gen_if.sv
// Control and sample bus of the waveform core.
// master = controlling top level, slave = waveform core.
interface saw_sin_noise_gen_if;
    import awg_pkg::*;

    logic                en_saw;
    logic                en_sin;
    logic                en_noise;
    logic [FREQ_W-1:0]   freq;
    logic [AMP_W-1:0]    amp;
    logic [PHASE_W-1:0]  phase;
    logic [SAMPLE_W-1:0] saw_a;
    logic [SAMPLE_W-1:0] saw_b;
    logic [SAMPLE_W-1:0] sin_a;
    logic [SAMPLE_W-1:0] sin_b;
    logic [SAMPLE_W-1:0] noise;

    modport master (
        output en_saw, en_sin, en_noise, freq, amp, phase,
        input  saw_a, saw_b, sin_a, sin_b, noise
    );

    modport slave (
        input  en_saw, en_sin, en_noise, freq, amp, phase,
        output saw_a, saw_b, sin_a, sin_b, noise
    );
endinterface

// File: rtl/sin_quarter_rom.sv
// Dual-read-port, synchronous quarter-wave sine ROM: ROM[k] = round(8191*sin((2k+1)*pi/1024)).
// Contents are built at elaboration with fixed-point Taylor series (56 fractional bits).
module sin_quarter_rom
    import awg_pkg::*;
(
    input  logic              clk,
    input  logic [ROM_AW-1:0] idx_a_i,
    input  logic [ROM_AW-1:0] idx_b_i,
    output logic [ROM_DW-1:0] mag_a_o,
    output logic [ROM_DW-1:0] mag_b_o
);

    localparam int                  FRAC     = 56;
    localparam logic signed [127:0] PI_FX    = 128'sh3243F6A8885A308;
    localparam logic signed [127:0] HALF_LSB = 128'sh80000000000000;

    function automatic logic [ROM_DW-1:0] sin_mag(input int k);
        logic signed [127:0] x;
        logic signed [127:0] x2;
        logic signed [127:0] term;
        logic signed [127:0] sum;
        x    = (128'(2 * k + 1) * PI_FX) >>> 10;
        x2   = (x * x) >>> FRAC;
        term = x;
        sum  = x;
        for (int n = 1; n <= 12; n++) begin
            term = -((term * x2) >>> FRAC) / 128'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        return ROM_DW'((sum * 128'sd8191 + HALF_LSB) >>> FRAC);
    endfunction

    logic [ROM_DW-1:0] rom_s [2**ROM_AW];
    logic [ROM_DW-1:0] mag_a_q;
    logic [ROM_DW-1:0] mag_b_q;

    for (genvar k = 0; k < 2**ROM_AW; k++) begin : g_rom
        localparam logic [ROM_DW-1:0] MAG = sin_mag(k);
        assign rom_s[k] = MAG;
    end

    always_ff @(posedge clk) begin
        mag_a_q <= rom_s[idx_a_i];
        mag_b_q <= rom_s[idx_b_i];
    end

    assign mag_a_o = mag_a_q;
    assign mag_b_o = mag_b_q;

endmodule

// File: rtl/saw_sin_noise_gen.sv
// AWG waveform core: phase accumulator feeding saw and sine channels (A and phase-offset B)
// through a two-stage pipeline, plus a free-running 16-bit Fibonacci LFSR noise source.
module saw_sin_noise_gen
    import awg_pkg::*;
#(
    parameter logic [ACC_W-1:0] LFSR_SEED = LFSR_SEED_DEF
)(
    input logic                clk,
    input logic                rst_n,
    saw_sin_noise_gen_if.slave bus
);

    logic [ACC_W-1:0]    acc_q;
    logic [ACC_W-1:0]    acc_d;
    logic [ACC_W-1:0]    lfsr_q;
    logic [ACC_W-1:0]    lfsr_d;
    logic [SAMPLE_W-1:0] word_b_s;
    logic [ROM_AW-1:0]   idx_a_s;
    logic [ROM_AW-1:0]   idx_b_s;
    logic [ROM_DW-1:0]   mag_a_s;
    logic [ROM_DW-1:0]   mag_b_s;

    logic [SAMPLE_W-1:0] saw_a_raw_q, saw_a_raw_d;
    logic [SAMPLE_W-1:0] saw_b_raw_q, saw_b_raw_d;
    logic                neg_a_q, neg_a_d;
    logic                neg_b_q, neg_b_d;
    logic [AMP_W-1:0]    amp_q, amp_d;
    logic                en_saw_q, en_saw_d;
    logic                en_sin_q, en_sin_d;

    logic [SAMPLE_W-1:0] sin_a_raw_s;
    logic [SAMPLE_W-1:0] sin_b_raw_s;
    logic [SAMPLE_W-1:0] saw_a_q, saw_a_d;
    logic [SAMPLE_W-1:0] saw_b_q, saw_b_d;
    logic [SAMPLE_W-1:0] sin_a_q, sin_a_d;
    logic [SAMPLE_W-1:0] sin_b_q, sin_b_d;

    // Accumulator clears whenever both waveform channels are idle
    always_comb begin
        if (bus.en_saw || bus.en_sin) begin
            acc_d = acc_q + {{(ACC_W-FREQ_W){1'b0}}, bus.freq};
        end else begin
            acc_d = 16'd0;
        end
        if (bus.en_noise) begin
            lfsr_d = lfsr_next(lfsr_q);
        end else begin
            lfsr_d = lfsr_q;
        end
    end

    // B address kept as addr[15:2]: the phase offset has no weight below bit 7
    assign word_b_s = acc_q[ACC_W-1:2] + {bus.phase, 5'd0};
    assign idx_a_s  = quarter_index(acc_q[14], acc_q[13:6]);
    assign idx_b_s  = quarter_index(word_b_s[12], word_b_s[11:4]);

    sin_quarter_rom u_rom (
        .clk     (clk),
        .idx_a_i (idx_a_s),
        .idx_b_i (idx_b_s),
        .mag_a_o (mag_a_s),
        .mag_b_o (mag_b_s)
    );

    always_comb begin
        saw_a_raw_d = acc_q[ACC_W-1:2];
        saw_b_raw_d = word_b_s;
        neg_a_d     = acc_q[ACC_W-1];
        neg_b_d     = word_b_s[SAMPLE_W-1];
        amp_d       = bus.amp;
        en_saw_d    = bus.en_saw;
        en_sin_d    = bus.en_sin;
    end

    // Stage 2: rebuild full sine from quarter-wave magnitude, scale, gate by delayed enables
    always_comb begin
        if (neg_a_q) begin
            sin_a_raw_s = MIDSCALE - {1'b0, mag_a_s};
        end else begin
            sin_a_raw_s = MIDSCALE + {1'b0, mag_a_s};
        end
        if (neg_b_q) begin
            sin_b_raw_s = MIDSCALE - {1'b0, mag_b_s};
        end else begin
            sin_b_raw_s = MIDSCALE + {1'b0, mag_b_s};
        end
        if (en_saw_q) begin
            saw_a_d = amp_scale(saw_a_raw_q, amp_q);
            saw_b_d = amp_scale(saw_b_raw_q, amp_q);
        end else begin
            saw_a_d = 14'd0;
            saw_b_d = 14'd0;
        end
        if (en_sin_q) begin
            sin_a_d = amp_scale(sin_a_raw_s, amp_q);
            sin_b_d = amp_scale(sin_b_raw_s, amp_q);
        end else begin
            sin_a_d = 14'd0;
            sin_b_d = 14'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q  <= 16'd0;
            lfsr_q <= LFSR_SEED;
        end else begin
            acc_q  <= acc_d;
            lfsr_q <= lfsr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            saw_a_raw_q <= 14'd0;
            saw_b_raw_q <= 14'd0;
            neg_a_q     <= 1'b0;
            neg_b_q     <= 1'b0;
            amp_q       <= 4'd0;
            en_saw_q    <= 1'b0;
            en_sin_q    <= 1'b0;
        end else begin
            saw_a_raw_q <= saw_a_raw_d;
            saw_b_raw_q <= saw_b_raw_d;
            neg_a_q     <= neg_a_d;
            neg_b_q     <= neg_b_d;
            amp_q       <= amp_d;
            en_saw_q    <= en_saw_d;
            en_sin_q    <= en_sin_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            saw_a_q <= 14'd0;
            saw_b_q <= 14'd0;
            sin_a_q <= 14'd0;
            sin_b_q <= 14'd0;
        end else begin
            saw_a_q <= saw_a_d;
            saw_b_q <= saw_b_d;
            sin_a_q <= sin_a_d;
            sin_b_q <= sin_b_d;
        end
    end

    assign bus.saw_a = saw_a_q;
    assign bus.saw_b = saw_b_q;
    assign bus.sin_a = sin_a_q;
    assign bus.sin_b = sin_b_q;
    assign bus.noise = lfsr_q[SAMPLE_W-1:0];

endmodule

// File: tb/tb_saw_sin_noise_gen.sv
// Self-checking bench for saw_sin_noise_gen: directed literal checks plus randomized
// stimulus compared every cycle against a behavioural waveform/LFSR model.
module tb_saw_sin_noise_gen;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    saw_sin_noise_gen_if bus_if ();

    saw_sin_noise_gen #(.LFSR_SEED(16'hACE1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int n_vec  = 0;
    int n_miss = 0;
    int rom_m [256];

    int acc_m, lfsr_m, lfsr_steps;
    bit snap_ok = 1'b0;
    int snap_acc, snap_phase, snap_amp;
    bit snap_en_saw, snap_en_sin;
    int e_saw_a, e_saw_b, e_sin_a, e_sin_b, e_noise;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int scale(input int s, input int a);
        if (a == 0) return 8192;
        return 8192 + ((s - 8192) >>> (a - 1));
    endfunction

    // Sine sample of a 16-bit phase address: quarter-wave table with mirror and sign
    function automatic int sin_of(input int addr);
        int q, i, m;
        q = addr / 16384;
        i = (addr / 64) % 256;
        m = rom_m[(q % 2 == 1) ? 255 - i : i];
        return (q >= 2) ? 8192 - m : 8192 + m;
    endfunction

    // Model: outputs after an edge are f(state sampled at the previous edge)
    always begin
        int fb;
        @(posedge clk);
        if (!rst_n) begin
            acc_m = 0; lfsr_m = 16'hACE1; lfsr_steps = 0; snap_ok = 1'b0;
            e_saw_a = 0; e_saw_b = 0; e_sin_a = 0; e_sin_b = 0;
        end else begin
            if (snap_ok) begin
                int ab;
                ab = (snap_acc + snap_phase * 128) % 65536;
                e_saw_a = snap_en_saw ? scale(snap_acc / 4, snap_amp) : 0;
                e_saw_b = snap_en_saw ? scale(ab / 4, snap_amp) : 0;
                e_sin_a = snap_en_sin ? scale(sin_of(snap_acc), snap_amp) : 0;
                e_sin_b = snap_en_sin ? scale(sin_of(ab), snap_amp) : 0;
            end else begin
                e_saw_a = 0; e_saw_b = 0; e_sin_a = 0; e_sin_b = 0;
            end
            snap_acc    = acc_m;
            snap_phase  = int'(bus_if.phase);
            snap_amp    = int'(bus_if.amp);
            snap_en_saw = bus_if.en_saw;
            snap_en_sin = bus_if.en_sin;
            snap_ok     = 1'b1;
            acc_m = (bus_if.en_saw || bus_if.en_sin) ? (acc_m + int'(bus_if.freq)) % 65536 : 0;
            if (bus_if.en_noise) begin
                fb = ((lfsr_m >> 15) ^ (lfsr_m >> 13) ^ (lfsr_m >> 12) ^ (lfsr_m >> 10)) & 1;
                lfsr_m = ((lfsr_m << 1) & 16'hFFFF) | fb;
                lfsr_steps++;
            end
        end
        e_noise = lfsr_m & 16'h3FFF;
        #1;
        check("saw_a", int'(bus_if.saw_a), e_saw_a);
        check("saw_b", int'(bus_if.saw_b), e_saw_b);
        check("sin_a", int'(bus_if.sin_a), e_sin_a);
        check("sin_b", int'(bus_if.sin_b), e_sin_b);
        check("noise", int'(bus_if.noise), e_noise);
    end

    task automatic rand_inputs(input bit keep_noise);
        bus_if.en_saw = ($urandom_range(0, 3) != 0);
        bus_if.en_sin = ($urandom_range(0, 3) != 0);
        if (!keep_noise) bus_if.en_noise = ($urandom_range(0, 7) != 0);
        case ($urandom_range(0, 3))
            0:       bus_if.freq = 12'd0;
            1:       bus_if.freq = 12'd4095;
            default: bus_if.freq = 12'($urandom_range(0, 4095));
        endcase
        bus_if.amp   = 4'($urandom_range(0, 15));
        bus_if.phase = 9'($urandom_range(0, 511));
    endtask

    initial begin
        int mx, mn, guard;
        for (int k = 0; k < 256; k++)
            rom_m[k] = $rtoi(8191.0 * $sin(real'(2 * k + 1) * 3.14159265358979323846 / 1024.0) + 0.5);
        check("rom_m0", rom_m[0], 25);
        check("rom_m255", rom_m[255], 8191);

        rst_n = 1'b0;
        bus_if.en_saw = 1'b1; bus_if.en_sin = 1'b1; bus_if.en_noise = 1'b1;
        bus_if.freq = 12'd100; bus_if.amp = 4'd1; bus_if.phase = 9'd0;
        repeat (3) begin
            @(posedge clk); #1;
            check("rst_noise", int'(bus_if.noise), 14'h2CE1);
            check("rst_saw_a", int'(bus_if.saw_a), 0);
            check("rst_sin_b", int'(bus_if.sin_b), 0);
        end
        @(negedge clk);
        rst_n = 1'b1; bus_if.en_saw = 1'b0; bus_if.en_sin = 1'b0;

        // Saw ramp, freq=1: one step every 4 cycles; phase 256 = half turn
        @(negedge clk);
        bus_if.en_saw = 1'b1; bus_if.freq = 12'd1; bus_if.amp = 4'd1; bus_if.phase = 9'd256;
        repeat (42) @(posedge clk);
        #1;
        check("saw_ramp_a", int'(bus_if.saw_a), 10);
        check("saw_half_b", int'(bus_if.saw_b), 8202);
        @(negedge clk);
        bus_if.phase = 9'd128;
        repeat (20) @(negedge clk);
        bus_if.en_saw = 1'b0;
        repeat (3) @(negedge clk);

        // Sine, freq=64: 1024-cycle period
        bus_if.en_sin = 1'b1; bus_if.freq = 12'd64; bus_if.amp = 4'd1;
        bus_if.phase = 9'($urandom_range(0, 511));
        repeat (2) @(posedge clk);
        #1;
        check("sin_first", int'(bus_if.sin_a), 8217);
        mx = 0; mn = 1 << 20;
        repeat (1024) begin
            @(posedge clk); #1;
            if (int'(bus_if.sin_a) > mx) mx = int'(bus_if.sin_a);
            if (int'(bus_if.sin_a) < mn) mn = int'(bus_if.sin_a);
        end
        check("sin_max_amp1", mx, 16383);
        check("sin_min_amp1", mn, 1);

        @(negedge clk);
        bus_if.amp = 4'd2;
        repeat (3) @(posedge clk);
        mx = 0; mn = 1 << 20;
        repeat (1024) begin
            @(posedge clk); #1;
            if (int'(bus_if.sin_a) > mx) mx = int'(bus_if.sin_a);
            if (int'(bus_if.sin_a) < mn) mn = int'(bus_if.sin_a);
        end
        check("sin_max_amp2", mx, 12287);
        check("sin_min_amp2", mn, 4096);

        @(negedge clk);
        bus_if.amp = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check("mute_sin_a", int'(bus_if.sin_a), 8192);
        check("mute_sin_b", int'(bus_if.sin_b), 8192);
        check("saw_off", int'(bus_if.saw_a), 0);

        @(negedge clk);
        bus_if.en_sin = 1'b0;
        @(posedge clk); #1;
        check("sin_off_lat1", int'(bus_if.sin_a), 8192);
        @(posedge clk); #1;
        check("sin_off_lat2", int'(bus_if.sin_a), 0);

        // Noise hold
        @(negedge clk);
        bus_if.en_noise = 1'b0;
        repeat (8) @(negedge clk);
        bus_if.en_noise = 1'b1;

        // Reset in the middle of activity
        bus_if.en_saw = 1'b1; bus_if.en_sin = 1'b1; bus_if.freq = 12'd777; bus_if.amp = 4'd3;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_saw_a", int'(bus_if.saw_a), 0);
        check("midrst_sin_a", int'(bus_if.sin_a), 0);
        check("midrst_noise", int'(bus_if.noise), 14'h2CE1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int c = 0; c < 2500; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 5) == 0) rand_inputs(1'b0);
        end

        // Run the LFSR to a full period of enabled steps since the last reset
        bus_if.en_noise = 1'b1;
        guard = 0;
        while (lfsr_steps != 65535 && guard < 70000) begin
            @(negedge clk);
            guard++;
            if ($urandom_range(0, 15) == 0) rand_inputs(1'b1);
        end
        check("lfsr_steps", lfsr_steps, 65535);
        check("lfsr_period", int'(bus_if.noise), 14'h2CE1);
        check("lfsr_model_seed", lfsr_m, 16'hACE1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
